// File: rtl/crossroads_pkg.sv
// Shared definitions for the crossroads safety monitor: fault codes,
// monitor state encoding, lamp aspect encoding and the aspect decoder.
package crossroads_pkg;

    localparam logic [2:0] FLT_NONE        = 3'd0;
    localparam logic [2:0] FLT_CONFLICT    = 3'd1;
    localparam logic [2:0] FLT_INVALID     = 3'd2;
    localparam logic [2:0] FLT_ILLEGAL     = 3'd3;
    localparam logic [2:0] FLT_SHORT_AMBER = 3'd4;
    localparam logic [2:0] FLT_WDOG        = 3'd5;

    typedef enum logic [1:0] {
        MON_ARM      = 2'd0,
        MON_RUN      = 2'd1,
        MON_FAILSAFE = 2'd2
    } mon_state_e;

    typedef enum logic [1:0] {
        ASP_RED   = 2'd0,
        ASP_AMBER = 2'd1,
        ASP_GREEN = 2'd2,
        ASP_BAD   = 2'd3
    } aspect_e;

    // Exactly one lit lamp gives a valid aspect; anything else is malformed.
    function automatic aspect_e decode_aspect(input logic red, input logic amber, input logic green);
        case ({red, amber, green})
            3'b100:  return ASP_RED;
            3'b010:  return ASP_AMBER;
            3'b001:  return ASP_GREEN;
            default: return ASP_BAD;
        endcase
    endfunction

endpackage

// File: rtl/crossroads_safety_monitor_approach_checker.sv
// Per-approach checker: decodes the aspect, flags malformed aspects,
// illegal sequencing and short amber, and owns the amber tick counter.
module approach_checker
    import crossroads_pkg::*;
#(
    parameter int MIN_AMBER = 3,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_clr,
    input  logic             tick,
    input  logic             red_i,
    input  logic             amber_i,
    input  logic             green_i,
    input  logic             prev_red,
    input  logic             prev_amber,
    input  logic             prev_green,
    output logic [1:0]       aspect,
    output logic             invalid,
    output logic             illegal_trans,
    output logic             short_amber
);

    aspect_e          cur_asp;
    aspect_e          prev_asp;
    logic [CNT_W-1:0] amber_cnt_q;
    logic [CNT_W-1:0] amber_cnt_d;
    logic [CNT_W-1:0] amber_inc;
    logic [CNT_W-1:0] amber_seen;

    assign aspect     = cur_asp;
    assign amber_inc  = (amber_cnt_q == '1) ? amber_cnt_q : amber_cnt_q + CNT_W'(1);
    // A tick landing on the amber-to-red cycle still belongs to amber.
    assign amber_seen = tick ? amber_inc : amber_cnt_q;

    // Decode current and previous aspects and evaluate the sequencing rules.
    always_comb begin
        cur_asp       = decode_aspect(red_i, amber_i, green_i);
        prev_asp      = decode_aspect(prev_red, prev_amber, prev_green);
        invalid       = (cur_asp == ASP_BAD);
        illegal_trans = ((prev_asp == ASP_GREEN) && (cur_asp == ASP_RED))   ||
                        ((prev_asp == ASP_AMBER) && (cur_asp == ASP_GREEN)) ||
                        ((prev_asp == ASP_RED)   && (cur_asp == ASP_AMBER));
        short_amber   = (prev_asp == ASP_AMBER) && (cur_asp == ASP_RED) &&
                        (amber_seen < CNT_W'(MIN_AMBER));
    end

    // Amber counter: zeroed on entry to amber, counts ticks while amber holds.
    always_comb begin
        amber_cnt_d = amber_cnt_q;
        if (cnt_clr) begin
            amber_cnt_d = '0;
        end else if ((cur_asp == ASP_AMBER) && (prev_asp != ASP_AMBER)) begin
            amber_cnt_d = '0;
        end else if ((cur_asp == ASP_AMBER) && tick) begin
            amber_cnt_d = amber_inc;
        end
    end

    // Amber counter register.
    always_ff @(posedge clk) begin
        if (rst) amber_cnt_q <= '0;
        else     amber_cnt_q <= amber_cnt_d;
    end

endmodule

// File: rtl/crossroads_safety_monitor.sv
// Conflict monitor and registered lamp-drive stage. Forwards the controller
// lamps one cycle late while healthy; on the first violation it latches a
// fault code and drives flashing red on both approaches until cleared.
module crossroads_safety_monitor
    import crossroads_pkg::*;
#(
    parameter int MIN_AMBER   = 3,
    parameter int MAX_HOLD    = 30,
    parameter int FLASH_TICKS = 1,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ns_red_i,
    input  logic       ns_amber_i,
    input  logic       ns_green_i,
    input  logic       ew_red_i,
    input  logic       ew_amber_i,
    input  logic       ew_green_i,
    input  logic       fault_clr,
    output logic       ns_red_o,
    output logic       ns_amber_o,
    output logic       ns_green_o,
    output logic       ew_red_o,
    output logic       ew_amber_o,
    output logic       ew_green_o,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] mon_state
);

    localparam logic [5:0] ALL_RED = 6'b100_100;

    mon_state_e       state_q, state_d;
    logic [5:0]       lamps_in, prev_q, prev_d, lamp_q, lamp_d;
    logic [CNT_W-1:0] hold_q, hold_d, hold_inc;
    logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d, flash_inc;
    logic             flash_lit_q, flash_lit_d;
    logic             fault_q, fault_d;
    logic [2:0]       code_q, code_d, first_code;
    logic [1:0]       ns_asp, ew_asp;
    logic             ns_invalid, ns_illegal, ns_short;
    logic             ew_invalid, ew_illegal, ew_short;
    logic             cnt_clr, conflict, same, wdog, clr_ok;

    assign lamps_in  = {ns_red_i, ns_amber_i, ns_green_i, ew_red_i, ew_amber_i, ew_green_i};
    assign cnt_clr   = (state_q != MON_RUN);
    assign hold_inc  = (hold_q == '1) ? hold_q : hold_q + CNT_W'(1);
    assign flash_inc = (flash_cnt_q == '1) ? flash_cnt_q : flash_cnt_q + CNT_W'(1);

    approach_checker #(.MIN_AMBER(MIN_AMBER), .CNT_W(CNT_W)) u_ns_checker (
        .clk(clk), .rst(rst), .cnt_clr(cnt_clr), .tick(tick),
        .red_i(ns_red_i), .amber_i(ns_amber_i), .green_i(ns_green_i),
        .prev_red(prev_q[5]), .prev_amber(prev_q[4]), .prev_green(prev_q[3]),
        .aspect(ns_asp), .invalid(ns_invalid), .illegal_trans(ns_illegal), .short_amber(ns_short)
    );

    approach_checker #(.MIN_AMBER(MIN_AMBER), .CNT_W(CNT_W)) u_ew_checker (
        .clk(clk), .rst(rst), .cnt_clr(cnt_clr), .tick(tick),
        .red_i(ew_red_i), .amber_i(ew_amber_i), .green_i(ew_green_i),
        .prev_red(prev_q[2]), .prev_amber(prev_q[1]), .prev_green(prev_q[0]),
        .aspect(ew_asp), .invalid(ew_invalid), .illegal_trans(ew_illegal), .short_amber(ew_short)
    );

    // Raw-input checks and first-fault priority (lowest code wins).
    always_comb begin
        conflict   = (ns_green_i | ns_amber_i) & (ew_green_i | ew_amber_i);
        same       = (lamps_in == prev_q);
        wdog       = same && tick && (hold_inc >= CNT_W'(MAX_HOLD));
        clr_ok     = fault_clr && (ns_asp == ASP_RED) && (ew_asp == ASP_RED);
        first_code = FLT_NONE;
        if (conflict)                     first_code = FLT_CONFLICT;
        else if (ns_invalid | ew_invalid) first_code = FLT_INVALID;
        else if (ns_illegal | ew_illegal) first_code = FLT_ILLEGAL;
        else if (ns_short | ew_short)     first_code = FLT_SHORT_AMBER;
        else if (wdog)                    first_code = FLT_WDOG;
    end

    // Monitor state sequencing: ARM for one cycle, RUN until a fault, FAILSAFE until cleared.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MON_ARM:      state_d = MON_RUN;
            MON_RUN:      if (first_code != FLT_NONE) state_d = MON_FAILSAFE;
            MON_FAILSAFE: if (clr_ok) state_d = MON_ARM;
            default:      state_d = MON_ARM;
        endcase
    end

    // Lamp, history, counter and fault-latch updates for each monitor state.
    always_comb begin
        prev_d      = prev_q;
        lamp_d      = lamp_q;
        hold_d      = hold_q;
        flash_cnt_d = flash_cnt_q;
        flash_lit_d = flash_lit_q;
        fault_d     = fault_q;
        code_d      = code_q;
        case (state_q)
            MON_ARM: begin
                prev_d = lamps_in;
                lamp_d = ALL_RED;
                hold_d = '0;
            end
            MON_RUN: begin
                if (first_code != FLT_NONE) begin
                    fault_d     = 1'b1;
                    code_d      = first_code;
                    lamp_d      = ALL_RED;
                    flash_cnt_d = '0;
                    flash_lit_d = 1'b1;
                end else begin
                    lamp_d = lamps_in;
                    prev_d = lamps_in;
                    if (!same)     hold_d = '0;
                    else if (tick) hold_d = hold_inc;
                end
            end
            MON_FAILSAFE: begin
                if (clr_ok) begin
                    fault_d     = 1'b0;
                    code_d      = FLT_NONE;
                    hold_d      = '0;
                    flash_cnt_d = '0;
                    flash_lit_d = 1'b0;
                    lamp_d      = ALL_RED;
                end else begin
                    if (tick) begin
                        if (flash_inc >= CNT_W'(FLASH_TICKS)) begin
                            flash_cnt_d = '0;
                            flash_lit_d = ~flash_lit_q;
                        end else begin
                            flash_cnt_d = flash_inc;
                        end
                    end
                    lamp_d = {flash_lit_d, 2'b00, flash_lit_d, 2'b00};
                end
            end
            default: lamp_d = ALL_RED;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= MON_ARM;
        else     state_q <= state_d;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= ALL_RED;
            lamp_q      <= ALL_RED;
            hold_q      <= '0;
            flash_cnt_q <= '0;
            flash_lit_q <= 1'b0;
            fault_q     <= 1'b0;
            code_q      <= FLT_NONE;
        end else begin
            prev_q      <= prev_d;
            lamp_q      <= lamp_d;
            hold_q      <= hold_d;
            flash_cnt_q <= flash_cnt_d;
            flash_lit_q <= flash_lit_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
        end
    end

    assign {ns_red_o, ns_amber_o, ns_green_o, ew_red_o, ew_amber_o, ew_green_o} = lamp_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign mon_state  = state_q;

endmodule

// File: doc/crossroads_safety_monitor.md
# crossroads_safety_monitor

Conflict monitor and lamp-drive stage sitting directly downstream of the traffic-light controller: consumes the six NS/EW lamp signals plus the shared 1-tick strobe, and forwards them registered to the lamp drivers. Every cycle it checks the aspects for conflicts, malformed aspects, illegal sequencing, short amber and a stalled controller. On the first violation it latches a fault code and forces both approaches to flashing red until cleared. The offending vector never reaches the lamp outputs.

## Interface
- MIN_AMBER, 3: minimum ticks an approach must show amber before going red.
- MAX_HOLD, 30: watchdog limit in ticks for an unchanged lamp vector.
- FLASH_TICKS, 1: ticks per half-period of failsafe red flashing.
- CNT_W, 8: width of all tick counters; counters saturate at 2^CNT_W-1.
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle strobe from the tick generator.
- ns_red_i, ns_amber_i, ns_green_i, ew_red_i, ew_amber_i, ew_green_i  in  1 each  controller lamp outputs.
- fault_clr  in  1  request to leave failsafe.
- ns_red_o, ns_amber_o, ns_green_o, ew_red_o, ew_amber_o, ew_green_o  out  1 each  registered lamp drives.
- fault  out  1  latched fault flag.
- fault_code  out  3  latched first-fault code; 0 = none.
- mon_state  out  2  debug: ARM=0, RUN=1, FAILSAFE=2.

## Operation
- States:
  - ARM: lasts exactly one cycle. Outputs all-red. Checks disabled. Input vector captured into prev. Then RUN.
  - RUN: checks are evaluated on the raw inputs against prev at every edge. With no violation, the lamp registers load the inputs and prev is updated. With any violation, the lamp registers load the failsafe pattern instead of the inputs, fault is set, fault_code is latched, and the state goes to FAILSAFE.
  - FAILSAFE: amber and green outputs are 0. ns_red_o and ew_red_o are equal and toggle every FLASH_TICKS ticks, starting lit. Checks disabled.
- Leaving FAILSAFE: fault_clr is accepted only when the inputs are exactly ns_red_i=1, ew_red_i=1 and the other four inputs 0. When accepted: go to ARM; clear fault, fault_code and all counters. Otherwise fault_clr is ignored.
- Fault codes. When several faults occur in the same cycle, the lowest code wins.
  - 1 conflict: (ns_green|ns_amber) & (ew_green|ew_amber).
  - 2 invalid aspect: an approach does not have exactly one lamp lit.
  - 3 illegal transition: per approach, only hold, G→A, A→R and R→G are legal. G→R, A→G and R→A are faults.
  - 4 short amber: A→R occurs with that approach's amber tick count < MIN_AMBER.
  - 5 watchdog: hold counter reaches MAX_HOLD.
- Amber counter, one per approach: cleared on entry to amber; +1 on each tick cycle while the input is amber, including the cycle of the tick that ends amber.
- Hold counter: cleared when the input vector differs from prev; +1 on each tick while it is unchanged. The fault is raised at the edge where the counter would reach MAX_HOLD.
- Flash counter: runs only in FAILSAFE; cleared on entry.

## Timing
- Reset values: ns_red_o=1, ew_red_o=1, other lamp outputs 0, fault=0, fault_code=0, mon_state=ARM, prev=all-red, all counters 0.
- Lamp path latency is 1 cycle in RUN: input at edge k appears on outputs after edge k.
- fault, fault_code and the failsafe lamp pattern appear after the same edge that samples the violating input.
- rst overrides everything at any time, including mid-FAILSAFE and during a fault_clr.
- A tick coinciding with a transition counts toward the old aspect.
- Counters saturate; they never wrap.

## Structure
- The shared package crossroads_pkg holds:
  - fault-code localparams (FLT_NONE..FLT_WDOG);
  - mon_state encoding;
  - aspect encoding (RED, AMBER, GREEN, BAD) used by the checker.
- Sub-module approach_checker, instantiated once per approach. It takes the three current and three prev lamps plus tick. It produces aspect, invalid, illegal_trans and short_amber, and owns that approach's amber counter.
- Conflict detection, watchdog, FSM, flash logic and output registers stay in the top level.

## Test plan
- Legal cycle with MIN_AMBER=3, MAX_HOLD=30, tick every 4 cycles: NS G(10 ticks)→A(3)→all-red(1)→EW G(10)→A(3) →
  - outputs equal the inputs delayed 1 cycle;
  - fault=0 for 3 full cycles.
- Conflict: ns_green_i=1 and ew_green_i=1 in the same cycle → after that edge fault=1, fault_code=1, green outputs never asserted, reds flash with period 2 ticks.
- Illegal transitions:
  - NS green→red directly → fault_code=3;
  - separate run: NS amber held for only 2 ticks then red → fault_code=4.
- Malformed aspect: ns_red_i=1 and ns_green_i=1 → fault_code=2. Simultaneous conflict plus malformed aspect → fault_code=1.
- Watchdog: inputs frozen at NS green for 30 ticks → fault_code=5 on the 30th tick edge; 29 ticks → no fault.
- Clear and reset:
  - fault_clr while inputs show NS green → ignored;
  - fault_clr with all-red inputs → ARM one cycle, then RUN, fault=0, fault_code=0;
  - rst asserted mid-FAILSAFE → all reset values next cycle.
